// File: rtl/nphy_toggle_pi_read_sequencer.sv
// Read sequencer for the toggle-mode PHY input buffer: resets, arms and drains the PHY FIFO.
// Optional idle-FIFO watchdog enabled by defining NPHY_PI_READ_TIMEOUT_EN.
module nphy_toggle_pi_read_sequencer #(
    parameter int unsigned BufferResetCycles = 4,
    parameter int unsigned TimeoutCycles     = 1023
) (
    input  logic        iSystemClock,
    input  logic        iModuleReset_n,
    input  logic        iCMDValid,
    input  logic [15:0] iCMDLength,
    output logic        oCMDReady,
    output logic        oCMDDone,
    output logic        oCMDError,
    output logic        oPI_BufferReset,
    output logic        oPI_Buff_WE,
    output logic        oPI_Buff_RE,
    output logic [2:0]  oPI_Buff_OutSel,
    input  logic        iPI_Buff_Empty,
    input  logic [15:0] iPI_DQ,
    input  logic        iPI_DelayReady,
    output logic [15:0] oReadData,
    output logic        oReadValid,
    input  logic        iReadReady
);

    typedef enum logic [2:0] {StIdle, StPreRst, StArm, StDrain, StFlush} tSeqState;

    localparam logic [3:0] PhaseLast = 4'(BufferResetCycles - 1);

    tSeqState    rState;
    tSeqState    wNextState;
    logic [15:0] rLength;
    logic [3:0]  rPhaseCnt;
    logic [15:0] rReqCount;
    logic [15:0] rDelCount;
    logic        rInFlight;
    logic [15:0] rBufData [2];
    logic        rBufHead;
    logic [1:0]  rBufCount;
    logic        rBufferReset;
    logic        rBuffWE;
    logic        rZeroDone;

    logic        wAccept;
    logic        wPop;
    logic        wPhaseDone;
    logic [15:0] wDelCountNext;
    logic [2:0]  wOccupancy;
    logic        wTimeout;
    logic        wFlushLast;

    assign wAccept       = oCMDReady && iCMDValid;
    assign wPop          = oReadValid && iReadReady;
    assign wPhaseDone    = (rPhaseCnt == PhaseLast);
    assign wDelCountNext = rDelCount + 16'(wPop);
    // Words held plus the word still in flight from the PHY, net of this cycle's pop.
    assign wOccupancy    = 3'(rBufCount) + 3'(rInFlight) - 3'(wPop);
    assign wFlushLast    = (rState == StFlush) && wPhaseDone;

    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            rState <= StIdle;
        end else begin
            rState <= wNextState;
        end
    end

    always_comb begin
        wNextState = rState;
        case (rState)
            StIdle: begin
                if (wAccept && (iCMDLength != 16'd0)) begin
                    wNextState = StPreRst;
                end
            end
            StPreRst: begin
                if (wPhaseDone) begin
                    wNextState = StArm;
                end
            end
            StArm: begin
                wNextState = StDrain;
            end
            StDrain: begin
                if ((wDelCountNext == rLength) || wTimeout) begin
                    wNextState = StFlush;
                end
            end
            StFlush: begin
                if (wPhaseDone) begin
                    wNextState = StIdle;
                end
            end
            default: begin
                wNextState = StIdle;
            end
        endcase
    end

    always_comb begin
        oCMDReady       = 1'b0;
        oPI_Buff_RE     = 1'b0;
        oPI_Buff_OutSel = 3'b000;
        oCMDDone        = rZeroDone || wFlushLast;
        oPI_BufferReset = rBufferReset;
        oPI_Buff_WE     = rBuffWE;
        oReadValid      = (rBufCount != 2'd0);
        oReadData       = rBufData[rBufHead];
        // Reset gating keeps the handshake quiet while the block is held in reset.
        if (rState == StIdle) begin
            oCMDReady = iPI_DelayReady && iModuleReset_n;
        end
        if ((rState == StDrain) && !iPI_Buff_Empty && (rReqCount < rLength)
            && (wOccupancy < 3'd2)) begin
            oPI_Buff_RE = 1'b1;
        end
    end

    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            rLength      <= 16'd0;
            rPhaseCnt    <= 4'd0;
            rReqCount    <= 16'd0;
            rDelCount    <= 16'd0;
            rInFlight    <= 1'b0;
            rBufferReset <= 1'b1;
            rBuffWE      <= 1'b0;
            rZeroDone    <= 1'b0;
        end else begin
            rZeroDone    <= wAccept && (iCMDLength == 16'd0);
            rBufferReset <= (wNextState == StPreRst) || (wNextState == StFlush);
            // Capture enable drops one edge after the last word has been requested.
            rBuffWE      <= (wNextState == StDrain) && (rReqCount != rLength);
            rInFlight    <= oPI_Buff_RE;
            if (wAccept) begin
                rLength <= iCMDLength;
            end
            if (rState != wNextState) begin
                rPhaseCnt <= 4'd0;
            end else if ((rState == StPreRst) || (rState == StFlush)) begin
                rPhaseCnt <= rPhaseCnt + 4'd1;
            end
            if (wAccept) begin
                rReqCount <= 16'd0;
            end else if (oPI_Buff_RE && (rReqCount < rLength)) begin
                rReqCount <= rReqCount + 16'd1;
            end
            if (wAccept) begin
                rDelCount <= 16'd0;
            end else if (wPop && (rDelCount < rLength)) begin
                rDelCount <= wDelCountNext;
            end
        end
    end

    // Two-entry output buffer; anything left over is dropped once draining ends.
    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            rBufData[0] <= 16'd0;
            rBufData[1] <= 16'd0;
            rBufHead    <= 1'b0;
            rBufCount   <= 2'd0;
        end else if (wNextState != StDrain) begin
            rBufHead  <= 1'b0;
            rBufCount <= 2'd0;
        end else begin
            if (rInFlight) begin
                rBufData[rBufHead ^ rBufCount[0]] <= iPI_DQ;
            end
            if (wPop) begin
                rBufHead <= ~rBufHead;
            end
            rBufCount <= rBufCount + 2'(rInFlight) - 2'(wPop);
        end
    end

`ifdef NPHY_PI_READ_TIMEOUT_EN
    localparam logic [9:0] TimeoutLimit = 10'(TimeoutCycles);

    logic [9:0] rWatchdog;
    logic       rTimedOut;
    logic       wStarved;

    assign wStarved  = (rState == StDrain) && iPI_Buff_Empty && !rInFlight;
    assign wTimeout  = wStarved && (rWatchdog == (TimeoutLimit - 10'd1));
    assign oCMDError = rTimedOut && wFlushLast;

    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            rWatchdog <= 10'd0;
            rTimedOut <= 1'b0;
        end else begin
            rWatchdog <= (wStarved && !wTimeout) ? (rWatchdog + 10'd1) : 10'd0;
            if (wAccept) begin
                rTimedOut <= 1'b0;
            end else if (wTimeout) begin
                rTimedOut <= 1'b1;
            end
        end
    end
`else
    logic [9:0] unusedTimeout;

    assign unusedTimeout = 10'(TimeoutCycles);
    assign wTimeout      = 1'b0;
    assign oCMDError     = 1'b0;
`endif

endmodule

// File: tb/tb_nphy_toggle_pi_read_sequencer.sv
// Bench for nphy_toggle_pi_read_sequencer: PHY FIFO model plus scoreboard of delivered words.
module tb_nphy_toggle_pi_read_sequencer;

    localparam int unsigned BufRst = 4;
    localparam int unsigned Tmo    = 16;

    logic        iSystemClock   = 1'b0;
    logic        iModuleReset_n = 1'b0;
    logic        iCMDValid      = 1'b0;
    logic [15:0] iCMDLength     = 16'd0;
    logic        iPI_Buff_Empty = 1'b1;
    logic [15:0] iPI_DQ         = 16'd0;
    logic        iPI_DelayReady = 1'b1;
    logic        iReadReady     = 1'b1;
    logic        oCMDReady, oCMDDone, oCMDError, oPI_BufferReset, oPI_Buff_WE, oPI_Buff_RE;
    logic [2:0]  oPI_Buff_OutSel;
    logic [15:0] oReadData;
    logic        oReadValid;

    nphy_toggle_pi_read_sequencer #(
        .BufferResetCycles(BufRst),
        .TimeoutCycles    (Tmo)
    ) dut (
        .iSystemClock   (iSystemClock),
        .iModuleReset_n (iModuleReset_n),
        .iCMDValid      (iCMDValid),
        .iCMDLength     (iCMDLength),
        .oCMDReady      (oCMDReady),
        .oCMDDone       (oCMDDone),
        .oCMDError      (oCMDError),
        .oPI_BufferReset(oPI_BufferReset),
        .oPI_Buff_WE    (oPI_Buff_WE),
        .oPI_Buff_RE    (oPI_Buff_RE),
        .oPI_Buff_OutSel(oPI_Buff_OutSel),
        .iPI_Buff_Empty (iPI_Buff_Empty),
        .iPI_DQ         (iPI_DQ),
        .iPI_DelayReady (iPI_DelayReady),
        .oReadData      (oReadData),
        .oReadValid     (oReadValid),
        .iReadReady     (iReadReady)
    );

    always #5 iSystemClock = ~iSystemClock;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    logic [15:0] phySrc [$];
    logic [15:0] phyFifo [$];
    logic [15:0] expWords [$];
    logic [15:0] gotWords [$];
    int          brRuns [$];
    int          readyMode = 0;
    logic        smpRe = 1'b0, smpWe = 1'b0, smpBr = 1'b0;

    int   cycle = 0, cmdLen = 0, reqCount = 0, brRun = 0;
    int   nAccept = 0, nDone = 0, acceptCycle = 0, doneCycle = 0, doneBrRun = 0;
    int   firstPop = -1, lastPop = 0, reCycles = 0, weCycles = 0;
    int   stallErr = 0, overErr = 0, weLate = 0, outSelErr = 0, strayErr = 0;
    logic errAtDone = 1'b0, doneBr = 1'b0;
    logic prevValid = 1'b0, prevReady = 1'b0, prevRe = 1'b0;
    logic [15:0] prevData = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // PHY model: captures source words while WE is high, pops on RE, clears on buffer reset.
    initial begin
        forever begin
            @(posedge iSystemClock);
            #1;
            if (smpBr) begin
                phyFifo.delete();
            end else begin
                if (smpRe) begin
                    if (phyFifo.size() > 0) iPI_DQ = phyFifo.pop_front();
                    else iPI_DQ = 16'hdead;
                end
                if (smpWe && phySrc.size() > 0) phyFifo.push_back(phySrc.pop_front());
            end
            iPI_Buff_Empty = (phyFifo.size() == 0);
            case (readyMode)
                0:       iReadReady = 1'b1;
                1:       iReadReady = ~iReadReady;
                default: iReadReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observer: the rules below are stated in terms of words requested vs. words delivered.
    initial begin
        forever begin
            @(negedge iSystemClock);
            cycle++;
            smpRe = oPI_Buff_RE;
            smpWe = oPI_Buff_WE;
            smpBr = oPI_BufferReset;
            if (!iModuleReset_n) begin
                brRun     = 0;
                prevValid = 1'b0;
                prevRe    = 1'b0;
            end else begin
                if (prevValid && !prevReady && (!oReadValid || oReadData !== prevData))
                    stallErr++;
                if (oPI_Buff_RE) begin
                    reCycles++;
                    if ((reqCount - gotWords.size() - int'(oReadValid && iReadReady)) >= 2
                        || reqCount >= cmdLen)
                        overErr++;
                end
                if (oPI_Buff_WE) begin
                    weCycles++;
                    if (reqCount == cmdLen && !prevRe) weLate++;
                end
                if (oPI_BufferReset) brRun++;
                else if (brRun != 0) begin
                    brRuns.push_back(brRun);
                    brRun = 0;
                end
                if (oPI_Buff_OutSel != 3'b000) outSelErr++;
                if (oCMDError && !oCMDDone) strayErr++;
                if (iCMDValid && oCMDReady) begin
                    nAccept++;
                    acceptCycle = cycle;
                end
                if (oCMDDone) begin
                    nDone++;
                    doneCycle = cycle;
                    doneBr    = oPI_BufferReset;
                    doneBrRun = brRun;
                    errAtDone = oCMDError;
                end
                if (oReadValid && iReadReady) begin
                    gotWords.push_back(oReadData);
                    if (firstPop < 0) firstPop = cycle;
                    lastPop = cycle;
                end
                if (oPI_Buff_RE) reqCount++;
                prevValid = oReadValid;
                prevReady = iReadReady;
                prevData  = oReadData;
                prevRe    = oPI_Buff_RE;
            end
        end
    end

    task automatic clearStats(input int len, input int nWords, input bit seqData);
        cmdLen = len; reqCount = 0; nAccept = 0; nDone = 0; firstPop = -1; lastPop = 0;
        reCycles = 0; weCycles = 0; stallErr = 0; overErr = 0; weLate = 0; strayErr = 0;
        errAtDone = 1'b0; gotWords.delete(); brRuns.delete(); expWords.delete();
        phySrc.delete();
        for (int i = 0; i < nWords; i++) begin
            if (seqData) phySrc.push_back(16'(i + 1));
            else phySrc.push_back(16'($urandom));
        end
        expWords = phySrc;
    endtask

    task automatic startCmd(input int len);
        iCMDValid  = 1'b1;
        iCMDLength = 16'(len);
        for (int i = 0; i < 50 && nAccept == 0; i++) @(posedge iSystemClock);
        #1;
        iCMDValid = 1'b0;
    endtask

    task automatic runCmd(input int len, input int nWords, input int mode, input bit seqData,
                          input bit noisy, input bit dropDly, input bit expTimeout);
        int expCount;
        @(posedge iSystemClock);
        #1;
        readyMode = mode;
        clearStats(len, nWords, seqData);
        startCmd(len);
        if (noisy) begin
            iCMDValid  = 1'b1;
            iCMDLength = 16'(len + 3);
        end
        if (dropDly) iPI_DelayReady = 1'b0;
        for (int i = 0; i < 3000 && nDone == 0; i++) @(posedge iSystemClock);
        #1;
        iCMDValid      = 1'b0;
        iPI_DelayReady = 1'b1;
        repeat (3) @(posedge iSystemClock);
        #1;
        expCount = expTimeout ? nWords : len;
        check("accepts", nAccept, 1);
        check("done_count", nDone, 1);
        check("words_delivered", gotWords.size(), expCount);
        for (int i = 0; i < expCount && i < gotWords.size(); i++)
            check("word_order", gotWords[i], expWords[i]);
        check("error_at_done", errAtDone, expTimeout);
        check("stall_stable", stallErr, 0);
        check("re_overcommit", overErr, 0);
        check("we_late", weLate, 0);
        check("outsel_zero", outSelErr, 0);
        check("stray_error", strayErr, 0);
        if (len == 0) begin
            check("zero_done_latency", doneCycle - acceptCycle, 1);
            check("zero_no_re", reCycles, 0);
            check("zero_no_we", weCycles, 0);
            check("zero_no_bufrst", brRuns.size() + brRun, 0);
        end else begin
            check("bufrst_pulses", brRuns.size(), 2);
            for (int i = 0; i < brRuns.size(); i++) check("bufrst_len", brRuns[i], BufRst);
            check("done_in_flush", doneBr, 1'b1);
            check("done_on_last_flush", doneBrRun, BufRst);
            check("we_seen", weCycles > 0, 1'b1);
            if (mode == 0 && !expTimeout)
                check("back_to_back", lastPop - firstPop, len - 1);
            if (expTimeout)
                check("timeout_wait", (doneCycle - lastPop) >= int'(Tmo), 1'b1);
        end
    endtask

    initial begin
        iCMDValid  = 1'b1;
        iCMDLength = 16'd5;
        repeat (3) @(posedge iSystemClock);
        #1;
        check("rst_bufrst", oPI_BufferReset, 1'b1);
        check("rst_ready", oCMDReady, 1'b0);
        check("rst_valid", oReadValid, 1'b0);
        check("rst_re_we", {oPI_Buff_RE, oPI_Buff_WE, oCMDDone, oCMDError}, 4'b0);
        iCMDValid = 1'b0;
        @(posedge iSystemClock);
        #1;
        iModuleReset_n = 1'b1;
        @(negedge iSystemClock);
        check("release_bufrst_held", oPI_BufferReset, 1'b1);
        @(posedge iSystemClock);
        #1;
        check("release_bufrst_drop", oPI_BufferReset, 1'b0);
        iPI_DelayReady = 1'b0;
        #1;
        check("ready_follows_delay0", oCMDReady, 1'b0);
        iPI_DelayReady = 1'b1;
        #1;
        check("ready_follows_delay1", oCMDReady, 1'b1);

        runCmd(8, 8, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        runCmd(4, 4, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCmd(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        runCmd(6, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        runCmd(5, 7, 2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Abort a command mid-flight with reset.
        @(posedge iSystemClock);
        #1;
        readyMode = 0;
        clearStats(8, 8, 1'b0);
        startCmd(8);
        for (int i = 0; i < 300 && gotWords.size() < 3; i++) @(posedge iSystemClock);
        #2;
        iModuleReset_n = 1'b0;
        #1;
        check("abort_words", gotWords.size(), 3);
        check("abort_bufrst", oPI_BufferReset, 1'b1);
        check("abort_quiet", {oPI_Buff_RE, oPI_Buff_WE, oReadValid, oCMDDone, oCMDReady}, 5'b0);
        check("abort_data", oReadData, 16'd0);
        repeat (4) @(posedge iSystemClock);
        #1;
        iModuleReset_n = 1'b1;
        repeat (4) @(posedge iSystemClock);
        #1;
        check("abort_no_done", nDone, 0);
        runCmd(5, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            int len;
            len = $urandom_range(1, 12);
            runCmd(len, len + $urandom_range(0, 4), $urandom_range(0, 2),
                   1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
`ifdef NPHY_PI_READ_TIMEOUT_EN
        runCmd(4, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/nphy_toggle_pi_read_sequencer.md
NPHY_TOGGLE_PI_READ_SEQUENCER -- requirements
Module: nphy_toggle_pi_read_sequencer

Interface
REQ-001 SHALL have parameter BufferResetCycles, default 4, meaning PHY input-buffer reset pulse length in iSystemClock cycles (1..15).
REQ-002 SHALL have parameter TimeoutCycles, default 1023, meaning the idle-FIFO watchdog limit in cycles (10-bit).
REQ-003 SHALL have one clock, iSystemClock; reset is asynchronous and active-low, named iModuleReset_n.
REQ-004 SHALL have ports:
  iSystemClock  in  1  clock
  iModuleReset_n  in  1  asynchronous active-low reset
  iCMDValid  in  1  read command request
  iCMDLength  in  16  number of 16-bit FIFO words to read
  oCMDReady  out  1  command accepted when high with iCMDValid
  oCMDDone  out  1  one-cycle completion pulse
  oCMDError  out  1  one-cycle timeout pulse, coincident with oCMDDone
  oPI_BufferReset  out  1  PHY input-buffer reset
  oPI_Buff_WE  out  1  PHY capture enable
  oPI_Buff_RE  out  1  PHY FIFO read strobe
  oPI_Buff_OutSel  out  3  PHY output select
  iPI_Buff_Empty  in  1  PHY FIFO empty
  iPI_DQ  in  16  PHY FIFO word, valid one cycle after oPI_Buff_RE
  iPI_DelayReady  in  1  PHY delay calibration ready
  oReadData  out  16  word to downstream
  oReadValid  out  1  downstream valid
  iReadReady  in  1  downstream ready

Function
REQ-005 SHALL implement states IDLE, PRERST, ARM, DRAIN, FLUSH.
REQ-006 IDLE: oCMDReady = iPI_DelayReady; on iCMDValid && oCMDReady, latch iCMDLength and go to PRERST; with length 0, instead pulse oCMDDone the next cycle and stay in IDLE.
REQ-007 PRERST: oPI_BufferReset high for exactly BufferResetCycles cycles, then ARM.
REQ-008 ARM: oPI_Buff_WE goes high one cycle after entry; move to DRAIN on the same edge.
REQ-009 DRAIN: oPI_Buff_WE stays high until the requested count equals the length, then deasserts on the next edge.
REQ-010 oPI_Buff_RE SHALL be high iff: state DRAIN, !iPI_Buff_Empty, requested < length, and (words held + words in flight - pop this cycle) < 2.
REQ-011 SHALL hold read data in a 2-entry output buffer.
  - iPI_DQ is captured on the cycle after oPI_Buff_RE.
  - Words are presented in FIFO order.
  - oReadData/oReadValid stay stable while oReadValid && !iReadReady.
REQ-012 Sustained throughput SHALL be one word per cycle while the FIFO is non-empty and iReadReady stays high.
REQ-013 When delivered count equals length, go to FLUSH.
  - FLUSH asserts oPI_BufferReset for BufferResetCycles cycles to discard surplus captured words.
  - oCMDDone pulses on the last FLUSH cycle.
  - Return to IDLE on the next edge.
REQ-014 oPI_Buff_OutSel SHALL be 3'b000 in every state.
REQ-015 Requested and delivered counters SHALL be 16-bit, never wrap, and saturate at the latched length.
REQ-016 iCMDValid outside IDLE SHALL be ignored (oCMDReady low).
REQ-017 iPI_DelayReady falling outside IDLE SHALL NOT affect the active command.

Reset
REQ-018 While iModuleReset_n is low, all of the following SHALL hold:
  - state is IDLE and counters are 0;
  - oPI_BufferReset = 1, all other outputs = 0;
  - the output buffer is empty.
REQ-019 Assertion mid-command SHALL abort it immediately with no oCMDDone.
  - After release, oPI_BufferReset drops on the first edge.
  - Operation resumes from IDLE.

Configuration
REQ-020 Macro NPHY_PI_READ_TIMEOUT_EN defined:
  - In DRAIN, a 10-bit watchdog counts cycles with iPI_Buff_Empty high and no word in flight, and clears otherwise.
  - At TimeoutCycles, go to FLUSH; oCMDError pulses with oCMDDone.
REQ-021 Macro undefined: no watchdog logic; DRAIN waits indefinitely and oCMDError is tied 0.

Verification
REQ-022 Length 8, FIFO pre-filled with 8 words 0x0001..0x0008, iReadReady=1 -> 8 back-to-back oReadValid beats in order; oCMDDone exactly once after the FLUSH pulse (4 cycles).
REQ-023 Length 4, iReadReady toggling 1/0 each cycle -> oReadData held stable while stalled; no oPI_Buff_RE while the buffer and in-flight words total 2; all 4 words delivered.
REQ-024 Length 0 -> oCMDDone one cycle after acceptance; oPI_BufferReset, oPI_Buff_WE and oPI_Buff_RE never assert.
REQ-025 With the macro, TimeoutCycles=16, length 4, only 2 words supplied -> after 16 empty cycles, FLUSH, then oCMDDone with oCMDError=1; 2 words delivered.
REQ-026 iModuleReset_n pulsed low after 3 of 8 words -> outputs immediately at reset values; no oCMDDone; a new command is accepted after release.
REQ-027 Surplus: FIFO holds 10 words, length 6 -> exactly 6 delivered; oPI_Buff_WE low once requested = 6; FLUSH reset asserted.
